spi_baud_generator: RTL
=======================

# spi_baud_generator

Generates the SPI serial clock `sclk` and the one-cycle edge strobes that pace the SPI shift register. It sits directly upstream of the shift register: its `miso_recieve_sclk`, `miso_recieve_sclk0`, `mosi_send_sclk` and `mosi_send_sclk0` outputs are the sample/shift enables that stage consumes. Its divisor inputs come from the APB control/baud registers and its mode inputs from the slave-select/mode controller.

## Interface
Parameters:
- none (all configuration is register-driven at run time)

Ports:
- `pclk`  in  1  APB clock; the only clock.
- `preset`  in  1  Reset, synchronous, active-high.
- `spi_mode`  in  2  Mode: 00 = run, 01 = wait, 10/11 = stop.
- `spiswai`  in  1  Stop-in-wait. In wait mode, 1 halts the generator.
- `ss`  in  1  Slave select, active-low. The generator runs only while 0.
- `cpol`  in  1  Clock polarity; sets the sclk idle level.
- `cpha`  in  1  Clock phase.
- `sppr`  in  3  Baud prescaler select.
- `spr`  in  3  Baud rate select.
- `sclk`  out  1  Serial clock.
- `miso_recieve_sclk`  out  1  Sample strobe, modes 0/3 (cpha==cpol).
- `miso_recieve_sclk0`  out  1  Sample strobe, modes 1/2 (cpha!=cpol).
- `mosi_send_sclk`  out  1  Shift strobe, modes 0/3.
- `mosi_send_sclk0`  out  1  Shift strobe, modes 1/2.
- `baud_rate_divisor`  out  12  Latched divisor, for status readback.

## Operation
- Divisor: `(sppr+1) * 2^(spr+1)`, computed at 12 bits. The range is 2 to 2048 and cannot overflow. Half period is `half = divisor/2`.
- Enable: `en = !ss && (spi_mode==00 || (spi_mode==01 && !spiswai))`.
- State machine has two states:
  - IDLE: `sclk = cpol`, count = 0, all strobes 0. The divisor is re-latched every cycle. On `en` = 1, go to ACTIVE.
  - ACTIVE: the divisor is frozen. On `en` = 0, go to IDLE.
- Counter in ACTIVE: if `count == half-1`, then count ← 0 and sclk ← ~sclk. Otherwise count ← count+1.
- Strobes are registered and asserted on the same pclk edge that toggles sclk. They are high for exactly one pclk cycle, in the cycle immediately after the sclk edge. Which strobe fires depends on the edge direction:
  - Rising sclk edge, cpha==cpol: `miso_recieve_sclk`.
  - Falling sclk edge, cpha==cpol: `mosi_send_sclk`.
  - Falling sclk edge, cpha!=cpol: `miso_recieve_sclk0`.
  - Rising sclk edge, cpha!=cpol: `mosi_send_sclk0`.
- At most one strobe is high in any cycle.
- Changes to `sppr`/`spr` during ACTIVE are ignored until the next pass through IDLE.
- Changes to `cpol`/`cpha` during ACTIVE are unsupported. The generator must not hang: strobe selection uses the live `cpha`/`cpol` values.

## Timing
- Reset values: `sclk` = 0, all strobes = 0, `baud_rate_divisor` = 2, count = 0, state IDLE.
- In the first cycle after reset (IDLE), `sclk` takes the value of `cpol`.
- Start: if `en` is first sampled high at edge N, the first sclk toggle and first strobe occur at edge N+half.
- Steady state: sclk toggles every `half` pclk cycles, giving a period of `divisor` pclk cycles at 50 % duty.
- Stop: if `en` is sampled low at edge M, then at edge M `sclk` ← cpol, count ← 0 and strobes ← 0. A partial half-period is truncated and no strobe is issued at M.
- Simultaneous `en` fall and a toggle condition: the disable wins; no strobe, sclk goes to cpol.
- Reset while ACTIVE: reset values are applied at that edge regardless of `en`.
- `baud_rate_divisor` is updated in every IDLE cycle and held constant in ACTIVE.

## Configuration
- Macro `SPI_WAIT_FREEZE_EN`.
- Defined: wait mode with `spiswai`=1 (and `ss`=0) freezes the generator. Count and `sclk` hold their values, strobes are 0, and the state stays ACTIVE. Clearing `spiswai` resumes counting from the held count, so the sclk phase is preserved.
- Undefined: that condition is treated as `en`=0, i.e. return to IDLE as on stop.
- `ss`=1 or stop mode always goes to IDLE in both builds.

## Test plan
- Reset, then cpol=1, ss=1 → `sclk`=0 in the reset cycle and 1 on the next cycle; all strobes 0; divisor=2.
- sppr=0, spr=0, cpol=0, cpha=0, ss=0, run → sclk toggles every pclk (period 2). `miso_recieve_sclk` and `mosi_send_sclk` alternate every cycle; the `_sclk0` strobes stay 0.
- sppr=2, spr=1 (divisor 12), cpol=1, cpha=0 → first toggle 6 cycles after enable, period 12. `miso_recieve_sclk0` follows each falling edge and `mosi_send_sclk0` each rising edge; divisor readback = 12.
- Mid-transfer, change spr 1→3 → period stays 12 until ss rises then falls again, after which the period is 48.
- ss rises at count=3 of half=6 → sclk returns to cpol on that edge, no strobe, count=0; re-enable restarts a full 6-cycle half period.
- Wait mode, spiswai=1 while ACTIVE → with `SPI_WAIT_FREEZE_EN`, sclk and count hold, and resume phase-continuous once spiswai=0. Without it, the generator goes IDLE and sclk = cpol.

Source files
------------

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: divides pclk by (sppr+1)*2^(spr+1) and emits one-cycle sample/shift strobes.
// Optional build macro SPI_WAIT_FREEZE_EN: wait mode with spiswai=1 freezes sclk and count instead of idling.
module spi_baud_generator (
  input  logic        pclk,
  input  logic        preset,
  input  logic [1:0]  spi_mode,
  input  logic        spiswai,
  input  logic        ss,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  output logic        sclk,
  output logic        miso_recieve_sclk,
  output logic        miso_recieve_sclk0,
  output logic        mosi_send_sclk,
  output logic        mosi_send_sclk0,
  output logic [11:0] baud_rate_divisor
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      r_state, w_state_next;
  logic [10:0] r_count, w_count_next;
  logic        r_sclk, w_sclk_next;
  logic        r_mr, w_mr_next;
  logic        r_mr0, w_mr0_next;
  logic        r_ms, w_ms_next;
  logic        r_ms0, w_ms0_next;
  logic [11:0] r_div, w_div_next;

  logic [11:0] w_prescale;
  logic [11:0] w_div_calc;
  logic [10:0] w_half_m1;
  logic        w_en;
  logic        w_freeze;

  assign w_prescale = {9'd0, sppr} + 12'd1;
  assign w_div_calc = w_prescale << ({1'b0, spr} + 4'd1);
  assign w_half_m1  = r_div[11:1] - 11'd1;
  assign w_en       = !ss && ((spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai));

`ifdef SPI_WAIT_FREEZE_EN
  assign w_freeze = !ss && (spi_mode == 2'b01) && spiswai;
`else
  assign w_freeze = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_sclk_next  = r_sclk;
    w_div_next   = r_div;
    w_mr_next    = 1'b0;
    w_mr0_next   = 1'b0;
    w_ms_next    = 1'b0;
    w_ms0_next   = 1'b0;
    case (r_state)
      IDLE: begin
        w_div_next   = w_div_calc;
        w_sclk_next  = cpol;
        w_count_next = 11'd0;
        if (w_en) w_state_next = ACTIVE;
      end
      ACTIVE: begin
        // Freeze must be tested first: it is a subset of the disabled condition.
        if (w_freeze) begin
          w_count_next = r_count;
        end else if (!w_en) begin
          w_state_next = IDLE;
          w_sclk_next  = cpol;
          w_count_next = 11'd0;
        end else if (r_count == w_half_m1) begin
          w_count_next = 11'd0;
          w_sclk_next  = ~r_sclk;
          if (cpha == cpol) begin
            w_mr_next = !r_sclk;
            w_ms_next = r_sclk;
          end else begin
            w_mr0_next = r_sclk;
            w_ms0_next = !r_sclk;
          end
        end else begin
          w_count_next = r_count + 11'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_count <= 11'd0;
      r_sclk  <= 1'b0;
      r_mr    <= 1'b0;
      r_mr0   <= 1'b0;
      r_ms    <= 1'b0;
      r_ms0   <= 1'b0;
      r_div   <= 12'd2;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sclk  <= w_sclk_next;
      r_mr    <= w_mr_next;
      r_mr0   <= w_mr0_next;
      r_ms    <= w_ms_next;
      r_ms0   <= w_ms0_next;
      r_div   <= w_div_next;
    end
  end

  assign sclk               = r_sclk;
  assign miso_recieve_sclk  = r_mr;
  assign miso_recieve_sclk0 = r_mr0;
  assign mosi_send_sclk     = r_ms;
  assign mosi_send_sclk0    = r_ms0;
  assign baud_rate_divisor  = r_div;

endmodule
